// File: rtl/ft245_fifo_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ft245_fifo_responder_if
// Brief    : FT245 strobe/data bus plus host-side byte streams.
// Revision : 1.0 - initial release
// ============================================================================
interface ft245_fifo_responder_if;
  logic       rd;
  logic       wr;
  logic [7:0] usbx_in;
  logic [7:0] usbx_out;
  logic       usbx_oe;
  logic       rxf;
  logic       txe;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;

  modport master (
    output rd, wr, usbx_in, host_rx_data, host_rx_valid, host_tx_ready,
    input  usbx_out, usbx_oe, rxf, txe, host_rx_ready, host_tx_data, host_tx_valid
  );

  modport slave (
    input  rd, wr, usbx_in, host_rx_data, host_rx_valid, host_tx_ready,
    output usbx_out, usbx_oe, rxf, txe, host_rx_ready, host_tx_data, host_tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/ft245_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : ft245_fifo_responder
// Brief    : FT245-style device end: RX/TX byte FIFOs answering RD/WR strobes
//            with FT245 flag and bus timing. Optional macro FT245_LOOPBACK_EN
//            adds a loopback input routing the TX FIFO into the RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_fifo_responder #(
  parameter int RX_AW     = 4,
  parameter int TX_AW     = 4,
  parameter int RD_LAT    = 2,   // >= 1
  parameter int PRECHARGE = 3    // >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FT245_LOOPBACK_EN
  input  logic                  loopback,
`endif
  ft245_fifo_responder_if.slave bus,
  output logic [RX_AW:0]        rx_level,
  output logic [TX_AW:0]        tx_level,
  output logic                  proto_err
);

  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int CNT_MAX  = (RD_LAT > PRECHARGE) ? RD_LAT : PRECHARGE;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRECHARGE - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DRIVE, R_PRE} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ACTIVE, T_PRE} tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;

  logic             rd_q, wr_q;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             rxf_q, rxf_d;
  logic             txe_q, txe_d;
  logic             oe_q, oe_d;
  logic [7:0]       out_q, out_d;
  logic [7:0]       cap_q, cap_d;
  logic             proto_q, proto_d;

  logic [RX_AW:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TX_AW:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       tx_mem_q [TX_DEPTH];

  logic       loop_en;
  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head;
  logic       loop_move;
  logic       host_rx_push, host_tx_pop;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0] rx_push_data;
  logic       rd_fall, rd_rise, wr_rise, wr_fall;

`ifdef FT245_LOOPBACK_EN
  assign loop_en = loopback;
`else
  assign loop_en = 1'b0;
`endif

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                    (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                    (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
  assign rx_level = rx_wptr_q - rx_rptr_q;
  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign rx_head  = rx_mem_q[rx_rptr_q[RX_AW-1:0]];
  assign tx_head  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];

  assign bus.host_rx_ready = ~rx_full & ~loop_en;
  assign bus.host_tx_valid = ~tx_empty & ~loop_en;
  assign bus.host_tx_data  = tx_head;
  assign bus.usbx_out      = out_q;
  assign bus.usbx_oe       = oe_q;
  assign bus.rxf           = rxf_q;
  assign bus.txe           = txe_q;
  assign proto_err         = proto_q;

  assign loop_move    = loop_en & ~tx_empty & ~rx_full;
  assign host_rx_push = bus.host_rx_valid & bus.host_rx_ready;
  assign host_tx_pop  = bus.host_tx_valid & bus.host_tx_ready;
  assign rx_push      = host_rx_push | loop_move;
  assign rx_push_data = loop_en ? tx_head : bus.host_rx_data;
  assign tx_pop       = host_tx_pop | loop_move;

  assign rd_fall = rd_q & ~bus.rd;
  assign rd_rise = ~rd_q & bus.rd;
  assign wr_rise = bus.wr & ~wr_q;
  assign wr_fall = ~bus.wr & wr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    tx_state_d = tx_state_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    rxf_d      = rxf_q;
    txe_d      = txe_q;
    oe_d       = oe_q;
    out_d      = out_q;
    cap_d      = cap_q;
    proto_d    = proto_q;
    rx_pop     = 1'b0;
    tx_push    = 1'b0;

    case (rx_state_q)
      R_IDLE: begin
        rxf_d    = rx_empty;
        rx_cnt_d = '0;
        if (rd_fall) begin
          if (rxf_q) proto_d = 1'b1;
          else       rx_state_d = R_WAIT;
        end
      end
      R_WAIT, R_DRIVE: begin
        if (rx_state_q == R_WAIT) out_d = rx_head;
        if (rd_rise) begin
          rx_pop     = 1'b1;
          oe_d       = 1'b0;
          rxf_d      = 1'b1;
          rx_cnt_d   = '0;
          rx_state_d = R_PRE;
        end else if (rx_state_q == R_WAIT) begin
          if (rx_cnt_q == RD_LAST) begin
            oe_d       = 1'b1;
            rx_state_d = R_DRIVE;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      R_PRE: begin
        rxf_d = 1'b1;
        // A strobe while the flag is still precharged is a protocol error too.
        if (rd_fall) proto_d = 1'b1;
        if (rx_cnt_q == PRE_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = R_IDLE;
    endcase

    case (tx_state_q)
      T_IDLE: begin
        txe_d    = tx_full;
        tx_cnt_d = '0;
        if (wr_rise) begin
          if (txe_q) begin
            proto_d = 1'b1;
          end else begin
            cap_d      = bus.usbx_in;
            tx_state_d = T_ACTIVE;
          end
        end
      end
      T_ACTIVE: begin
        if (bus.wr) cap_d = bus.usbx_in;
        if (wr_fall) begin
          tx_push    = 1'b1;
          txe_d      = 1'b1;
          tx_cnt_d   = '0;
          tx_state_d = T_PRE;
        end
      end
      T_PRE: begin
        txe_d = 1'b1;
        if (wr_rise) proto_d = 1'b1;
        if (tx_cnt_q == PRE_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    rx_wptr_d = rx_wptr_q + {{RX_AW{1'b0}}, rx_push};
    rx_rptr_d = rx_rptr_q + {{RX_AW{1'b0}}, rx_pop};
    tx_wptr_d = tx_wptr_q + {{TX_AW{1'b0}}, tx_push};
    tx_rptr_d = tx_rptr_q + {{TX_AW{1'b0}}, tx_pop};
  end

  // Edge registers track the pins even in reset so a strobe held across
  // reset release is not seen as a fresh edge.
  always_ff @(posedge clk) begin
    rd_q <= bus.rd;
    wr_q <= bus.wr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rxf_q      <= 1'b1;
      txe_q      <= 1'b1;
      oe_q       <= 1'b0;
      out_q      <= 8'h00;
      cap_q      <= 8'h00;
      proto_q    <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rxf_q      <= rxf_d;
      txe_q      <= txe_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      cap_q      <= cap_d;
      proto_q    <= proto_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rx_push) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_push_data;
    if (!rst && tx_push) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= cap_q;
  end

endmodule
`default_nettype wire
